// File: rtl/mu_pkg.sv
// Shared definitions for the pipelined RV32M/RV64M multiply unit:
// operation encodings, legal pipeline depth and operand-extension helpers.
package mu_pkg;

  typedef enum logic [1:0] {
    MU_MUL    = 2'b00,
    MU_MULH   = 2'b01,
    MU_MULHSU = 2'b10,
    MU_MULHU  = 2'b11
  } mulctl_t;

  localparam int MU_CTL_W      = 2;
  localparam int MU_STAGES_MIN = 1;
  localparam int MU_STAGES_MAX = 8;

  // Returns {a_is_signed, b_is_signed} for an operation code.
  function automatic logic [1:0] mu_ext_signs(input logic [1:0] ctl);
    logic [1:0] s;
    s = 2'b00;
    case (ctl)
      MU_MULH:   s = 2'b11;
      MU_MULHSU: s = 2'b10;
      default:   s = 2'b00;
    endcase
    return s;
  endfunction

  // Fill bit used when widening an operand: its MSB if signed, else zero.
  function automatic logic mu_fill(input logic msb, input logic is_signed);
    return msb & is_signed;
  endfunction

endpackage

// File: rtl/mu_pipe_stage.sv
// One register slice of the multiply pipe: carries {valid, mulctl, tag,
// product}. Holds when en=0; valid is cleared synchronously by clr.
module mu_pipe_stage
  import mu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int TAGW = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         clr,
  input  logic                         d_vld,
  input  logic [MU_CTL_W-1:0]          d_ctl,
  input  logic [TAGW-1:0]              d_tag,
  input  logic signed [2*XLEN-1:0]     d_prod,
  output logic                         q_vld,
  output logic [MU_CTL_W-1:0]          q_ctl,
  output logic [TAGW-1:0]              q_tag,
  output logic signed [2*XLEN-1:0]     q_prod
);

  // Valid bit: clear wins over advance so a flush empties every slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_vld <= 1'b0;
    end else if (clr) begin
      q_vld <= 1'b0;
    end else if (en) begin
      q_vld <= d_vld;
    end
  end

  // Payload: reset to zero so the unit's outputs read zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_ctl  <= '0;
      q_tag  <= '0;
      q_prod <= '0;
    end else if (en) begin
      q_ctl  <= d_ctl;
      q_tag  <= d_tag;
      q_prod <= d_prod;
    end
  end

endmodule

// File: rtl/mu_pipe.sv
// Pipelined RISC-V M-extension multiply unit (MUL/MULH/MULHSU/MULHU).
// The whole pipe advances together whenever the output slot is free or
// being consumed; bubbles travel with the ops and are not squeezed out.
module mu_pipe
  import mu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int STAGES = 3,
  parameter int TAGW   = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [XLEN-1:0]     a,
  input  logic [XLEN-1:0]     b,
  input  logic [1:0]          mulctl,
  input  logic [TAGW-1:0]     tag_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     mulres,
  output logic [TAGW-1:0]     tag_out
);

  localparam int PW = 2 * XLEN;

  if (STAGES < MU_STAGES_MIN || STAGES > MU_STAGES_MAX) begin : g_bad_depth
    $error("mu_pipe: STAGES out of range");
  end

  logic                advance;
  logic                accept;
  logic [1:0]          sg;
  logic                fill_a;
  logic                fill_b;
  logic signed [PW-1:0] ext_a;
  logic signed [PW-1:0] ext_b;
  logic signed [PW-1:0] prod;

  // Index 0 is the incoming op; index i+1 is the output of slice i.
  logic                vld  [0:STAGES];
  logic [MU_CTL_W-1:0] ctl  [0:STAGES];
  logic [TAGW-1:0]     tag  [0:STAGES];
  logic signed [PW-1:0] prd [0:STAGES];

  assign out_valid = vld[STAGES];
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance && !flush;
  assign accept    = in_valid && in_ready;

  // Widen both operands to 2*XLEN and multiply. Only the low 2*XLEN bits of
  // the (XLEN+1)x(XLEN+1) signed product are ever selected, and those bits
  // are identical whether the operands are extended to XLEN+1 or 2*XLEN.
  always_comb begin
    sg     = mu_ext_signs(mulctl);
    fill_a = mu_fill(a[XLEN-1], sg[1]);
    fill_b = mu_fill(b[XLEN-1], sg[0]);
    ext_a  = {{XLEN{fill_a}}, a};
    ext_b  = {{XLEN{fill_b}}, b};
    prod   = ext_a * ext_b;
  end

  assign vld[0] = accept;
  assign ctl[0] = mulctl;
  assign tag[0] = tag_in;
  assign prd[0] = prod;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    // --- pipeline stage i boundary ---
    mu_pipe_stage #(
      .XLEN (XLEN),
      .TAGW (TAGW)
    ) u_stage (
      .clk    (clk),
      .rst    (rst),
      .en     (advance),
      .clr    (flush),
      .d_vld  (vld[i]),
      .d_ctl  (ctl[i]),
      .d_tag  (tag[i]),
      .d_prod (prd[i]),
      .q_vld  (vld[i+1]),
      .q_ctl  (ctl[i+1]),
      .q_tag  (tag[i+1]),
      .q_prod (prd[i+1])
    );
  end

  // MUL takes the low half of the product; every high variant the upper half.
  assign mulres  = (ctl[STAGES] == MU_MUL) ? prd[STAGES][XLEN-1:0]
                                           : prd[STAGES][PW-1:XLEN];
  assign tag_out = tag[STAGES];

endmodule

// File: tb/tb_mu_pipe.sv
// Directed bench for mu_pipe: a 32-bit/3-stage instance and a
// 64-bit/1-stage instance driven from one linear stimulus sequence.
module tb_mu_pipe;
  import mu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, mulres;
  logic [1:0]  mulctl;
  logic [4:0]  tag_in, tag_out;

  logic        w_flush, w_in_valid, w_in_ready, w_out_valid, w_out_ready;
  logic [63:0] w_a, w_b, w_mulres;
  logic [1:0]  w_mulctl;
  logic [4:0]  w_tag_in, w_tag_out;

  int checks = 0;
  int errors = 0;

  mu_pipe #(.XLEN(32), .STAGES(3), .TAGW(5)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .mulctl(mulctl), .tag_in(tag_in), .out_valid(out_valid),
    .out_ready(out_ready), .mulres(mulres), .tag_out(tag_out)
  );

  mu_pipe #(.XLEN(64), .STAGES(1), .TAGW(5)) dut64 (
    .clk(clk), .rst(rst), .flush(w_flush), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .a(w_a), .b(w_b), .mulctl(w_mulctl), .tag_in(w_tag_in), .out_valid(w_out_valid),
    .out_ready(w_out_ready), .mulres(w_mulres), .tag_out(w_tag_out)
  );

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // Check the 32-bit instance output triple.
  task automatic chk_out(input string name, input logic v, input logic [31:0] r, input logic [4:0] t);
    chk({name, ".valid"}, 64'(out_valid), 64'(v));
    if (v) begin
      chk({name, ".res"}, 64'(mulres), 64'(r));
      chk({name, ".tag"}, 64'(tag_out), 64'(t));
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic v, input logic [31:0] aa, input logic [31:0] bb,
                    input logic [1:0] c, input logic [4:0] t);
    in_valid = v;
    a        = aa;
    b        = bb;
    mulctl   = c;
    tag_in   = t;
  endtask

  task automatic wop(input logic v, input logic [63:0] aa, input logic [63:0] bb,
                     input logic [1:0] c, input logic [4:0] t);
    w_in_valid = v;
    w_a        = aa;
    w_b        = bb;
    w_mulctl   = c;
    w_tag_in   = t;
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0; out_ready = 1'b1;
    op(1'b0, 32'd0, 32'd0, MU_MUL, 5'd0);
    w_flush = 1'b0; w_out_ready = 1'b1;
    wop(1'b0, 64'd0, 64'd0, MU_MUL, 5'd0);

    // Reset state
    #2;
    chk("rst.ov32",  64'(out_valid), 64'd0);
    chk("rst.res32", 64'(mulres),    64'd0);
    chk("rst.tag32", 64'(tag_out),   64'd0);
    chk("rst.ov64",  64'(w_out_valid), 64'd0);
    chk("rst.res64", w_mulres,          64'd0);
    #10;
    rst = 1'b0;
    #1;
    chk("rst.rdy32", 64'(in_ready),   64'd1);
    chk("rst.rdy64", 64'(w_in_ready), 64'd1);
    cyc();

    // Four ops back-to-back, a=-3 b=-4
    op(1'b1, 32'hFFFFFFFD, 32'hFFFFFFFC, MU_MUL, 5'd1);
    cyc();
    chk_out("t1.lat1", 1'b0, 32'd0, 5'd0);
    op(1'b1, 32'hFFFFFFFD, 32'hFFFFFFFC, MU_MULH, 5'd2);
    cyc();
    chk_out("t1.lat2", 1'b0, 32'd0, 5'd0);
    op(1'b1, 32'hFFFFFFFD, 32'hFFFFFFFC, MU_MULHSU, 5'd3);
    cyc();
    chk_out("t1.mul", 1'b1, 32'd12, 5'd1);
    op(1'b1, 32'hFFFFFFFD, 32'hFFFFFFFC, MU_MULHU, 5'd4);
    cyc();
    chk_out("t1.mulh", 1'b1, 32'h00000000, 5'd2);
    op(1'b0, 32'd0, 32'd0, MU_MUL, 5'd0);
    cyc();
    chk_out("t1.mulhsu", 1'b1, 32'hFFFFFFFD, 5'd3);
    cyc();
    chk_out("t1.mulhu", 1'b1, 32'hFFFFFFF9, 5'd4);
    cyc();
    chk_out("t1.drain", 1'b0, 32'd0, 5'd0);

    // Single op, latency and one-cycle valid pulse
    op(1'b1, 32'd16, 32'd48, MU_MUL, 5'd7);
    cyc();
    op(1'b0, 32'd0, 32'd0, MU_MUL, 5'd0);
    chk_out("t2.c1", 1'b0, 32'd0, 5'd0);
    cyc();
    chk_out("t2.c2", 1'b0, 32'd0, 5'd0);
    cyc();
    chk_out("t2.c3", 1'b1, 32'd768, 5'd7);
    cyc();
    chk_out("t2.c4", 1'b0, 32'd0, 5'd0);

    // Backpressure: five ops, output stalled four cycles
    op(1'b1, 32'd100, 32'd3, MU_MUL, 5'd10);
    cyc();
    op(1'b1, 32'd101, 32'd3, MU_MUL, 5'd11);
    cyc();
    op(1'b1, 32'd102, 32'd3, MU_MUL, 5'd12);
    cyc();
    chk_out("t3.first", 1'b1, 32'd300, 5'd10);
    out_ready = 1'b0;
    op(1'b1, 32'd103, 32'd3, MU_MUL, 5'd13);
    #1;
    chk("t3.rdy0", 64'(in_ready), 64'd0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk_out("t3.hold", 1'b1, 32'd300, 5'd10);
      chk("t3.rdyhold", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("t3.rdy1", 64'(in_ready), 64'd1);
    cyc();
    chk_out("t3.r11", 1'b1, 32'd303, 5'd11);
    op(1'b1, 32'd104, 32'd3, MU_MUL, 5'd14);
    cyc();
    chk_out("t3.r12", 1'b1, 32'd306, 5'd12);
    op(1'b0, 32'd0, 32'd0, MU_MUL, 5'd0);
    cyc();
    chk_out("t3.r13", 1'b1, 32'd309, 5'd13);
    cyc();
    chk_out("t3.r14", 1'b1, 32'd312, 5'd14);
    cyc();
    chk_out("t3.empty", 1'b0, 32'd0, 5'd0);

    // Flush with ops in flight and an input held during the flush cycle
    op(1'b1, 32'd5, 32'd5, MU_MUL, 5'd20);
    cyc();
    op(1'b1, 32'd6, 32'd6, MU_MUL, 5'd21);
    cyc();
    op(1'b1, 32'd7, 32'd7, MU_MUL, 5'd22);
    flush = 1'b1;
    #1;
    chk("t4.rdyflush", 64'(in_ready), 64'd0);
    cyc();
    flush = 1'b0;
    op(1'b0, 32'd0, 32'd0, MU_MUL, 5'd0);
    for (int i = 0; i < 4; i++) begin
      chk_out("t4.gone", 1'b0, 32'd0, 5'd0);
      cyc();
    end

    // Asynchronous reset with ops in flight
    op(1'b1, 32'd7, 32'd9, MU_MUL, 5'd5);
    cyc();
    op(1'b1, 32'd2, 32'd2, MU_MUL, 5'd6);
    cyc();
    op(1'b0, 32'd0, 32'd0, MU_MUL, 5'd0);
    cyc();
    chk_out("t5.pre", 1'b1, 32'd63, 5'd5);
    #2;
    rst = 1'b1;
    #1;
    chk("t5.ov",  64'(out_valid), 64'd0);
    chk("t5.res", 64'(mulres),    64'd0);
    chk("t5.tag", 64'(tag_out),   64'd0);
    #1;
    rst = 1'b0;
    #1;
    chk("t5.rdy", 64'(in_ready), 64'd1);
    op(1'b1, 32'd5, 32'd6, MU_MUL, 5'd9);
    cyc();
    op(1'b0, 32'd0, 32'd0, MU_MUL, 5'd0);
    chk_out("t5.c1", 1'b0, 32'd0, 5'd0);
    cyc();
    chk_out("t5.c2", 1'b0, 32'd0, 5'd0);
    cyc();
    chk_out("t5.c3", 1'b1, 32'd30, 5'd9);
    cyc();
    chk_out("t5.c4", 1'b0, 32'd0, 5'd0);

    // 64-bit, single stage
    wop(1'b1, 64'hFFFFFFFFFFFFFFFF, 64'd2, MU_MULHU, 5'd1);
    cyc();
    chk("t6.ov1",  64'(w_out_valid), 64'd1);
    chk("t6.mulhu", w_mulres, 64'd1);
    chk("t6.tag1", 64'(w_tag_out), 64'd1);
    wop(1'b1, 64'hFFFFFFFFFFFFFFFF, 64'd2, MU_MULH, 5'd2);
    cyc();
    chk("t6.mulh", w_mulres, 64'hFFFFFFFFFFFFFFFF);
    chk("t6.tag2", 64'(w_tag_out), 64'd2);
    wop(1'b1, 64'hFFFFFFFFFFFFFFFF, 64'd2, MU_MUL, 5'd3);
    cyc();
    chk("t6.mul", w_mulres, 64'hFFFFFFFFFFFFFFFE);
    chk("t6.tag3", 64'(w_tag_out), 64'd3);
    wop(1'b0, 64'd0, 64'd0, MU_MUL, 5'd0);
    cyc();
    chk("t6.ov0", 64'(w_out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mu_pipe.md
Name: mu_pipe

Overview:
- Parametrised, pipelined successor to the single-shot multiply unit.
- Executes RV32M/RV64M MUL, MULH, MULHSU and MULHU on XLEN-bit operands over a configurable number of pipeline stages.
- Uses a valid/ready handshake on both sides, a destination tag carried through the pipe, and a flush input.
- Sits between the issue stage and the writeback arbiter; multiple multiplies can be in flight at once.

Parameters:
- XLEN, 32, operand and result width (32 or 64).
- STAGES, 3, pipeline depth; legal range 1 to 8; equals accept-to-result latency when not stalled.
- TAGW, 5, width of the tag carried alongside each operation (rd index).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  discards all in-flight operations.
- in_valid  input  1  operands and control are valid this cycle.
- in_ready  output  1  pipe accepts an operation this cycle.
- a  input  XLEN  rs1 operand.
- b  input  XLEN  rs2 operand.
- mulctl  input  2  operation: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- tag_in  input  TAGW  destination tag.
- out_valid  output  1  mulres and tag_out hold a completed result.
- out_ready  input  1  consumer takes the result this cycle.
- mulres  output  XLEN  result.
- tag_out  output  TAGW  tag of the result.

Behaviour:
- Reset (async, any time, including mid-operation):
  - all stage valid bits clear to 0; out_valid=0, mulres=0, tag_out=0.
  - in_ready becomes 1 once rst is released.
- Operand extension, at stage 0:
  - a is sign-extended to XLEN+1 bits for mulctl 01 and 10, zero-extended for 00 and 11.
  - b is sign-extended for 01 only, zero-extended otherwise.
  - Signed (XLEN+1)x(XLEN+1) product, 2*XLEN+2 bits.
- Result select:
  - mulctl 00 returns product[XLEN-1:0].
  - All other codes return product[2*XLEN-1:XLEN].
- Pipeline control:
  - advance = !out_valid | out_ready.
  - in_ready = advance & !flush.
  - Accept = in_valid & in_ready.
  - On advance, every stage register shifts forward one position; stage 0 loads the accepted op, or a bubble (valid=0) if nothing is accepted.
  - When advance=0 the whole pipe holds, and mulres/tag_out stay stable while out_valid=1.
  - Bubbles between ops are not compressed.
- Latency: an op accepted at edge N appears with out_valid=1 after edge N+STAGES if advance stays 1. Throughput is one op per cycle.
- Pipelining of arithmetic:
  - The product is computed in stage 0's register.
  - Later stages carry product, mulctl and tag.
  - Synthesis retiming is permitted; the cycle behaviour must match the spec exactly.
- Flush:
  - At the next edge, every stage valid bit including the output clears.
  - An input presented in the flush cycle is not accepted.
  - Flush takes priority over out_ready. A result offered in the flush cycle is only consumed if out_ready=1 in that same cycle; otherwise it is lost.
- Simultaneous events:
  - With the output full and out_ready=1, a new input is accepted in the same cycle.
  - With the output full and out_ready=0, in_ready=0.
- Overflow: none signalled; results wrap modulo 2^XLEN per the RISC-V M spec.
- STAGES=1: the result is registered once, and out_valid rises the cycle after accept.

Decomposition:
- Shared package mu_pkg holds:
  - mulctl encodings MU_MUL=2'b00, MU_MULH=2'b01, MU_MULHSU=2'b10, MU_MULHU=2'b11.
  - the legal STAGES bounds.
  - a helper function for operand extension.
- One sub-module, mu_pipe_stage: a valid-qualified register slice with enable (advance), synchronous clear (flush) and async reset. It is instantiated STAGES times via generate and carries {valid, mulctl, tag, product}.

Test Plan:
- XLEN=32, STAGES=3, a=-3, b=-4, all four mulctl back-to-back, out_ready=1 → results 12, 0x00000000, 0xFFFFFFFD, 0xFFFFFFF9 on four consecutive cycles starting 3 edges after the first accept, with tags 1,2,3,4 in order.
- a=16, b=48, MUL, tag=7 → mulres=768, tag_out=7 exactly 3 cycles after accept; out_valid pulses for 1 cycle.
- Backpressure: issue 5 ops, hold out_ready=0 for 4 cycles once out_valid=1 → in_ready=0 while full, mulres stable. On release, all 5 results appear in order with no loss or duplication.
- Flush with 3 ops in flight (out_ready=1) → out_valid=0 from the next edge, none of the 3 tags ever appear, and an in_valid held during the flush cycle is not accepted.
- Assert rst mid-stream with 2 ops in flight → out_valid, mulres and tag_out go to 0 immediately, without waiting for a clock edge; the first op after release has normal latency.
- XLEN=64, STAGES=1: a=0xFFFFFFFFFFFFFFFF, b=2, MULHU → 1; MULH → 0xFFFFFFFFFFFFFFFF; MUL → 0xFFFFFFFFFFFFFFFE, each with latency 1.
